// File: rtl/text_line_segmenter_pkg.sv
// Shared types for the text line segmenter: FSM state encoding, line record layout
// and the popcount width helper.
package seg_pkg;

    // Package-default field widths; the record struct is sized from these.
    localparam int unsigned SEG_ADDR_W = 4;
    localparam int unsigned SEG_INK_W  = 16;

    typedef enum logic [2:0] {
        IDLE,
        GAP,
        RUN,
        EMIT,
        FLUSH
    } seg_state_t;

    typedef struct packed {
        logic [SEG_ADDR_W-1:0] start_row;
        logic [SEG_ADDR_W-1:0] end_row;
        logic [SEG_INK_W-1:0]  ink;
    } line_rec_t;

    // Bits needed to hold a ones count of 0..dw inclusive.
    function automatic int unsigned pop_width(input int unsigned dw);
        return $clog2(dw + 1);
    endfunction

endpackage

// File: rtl/text_line_segmenter_row_popcount.sv
// Combinational ones counter over one packed pixel row.
module row_popcount
    import seg_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned CNT_W      = pop_width(DATA_WIDTH)
) (
    input  logic [DATA_WIDTH-1:0] i_row,
    output logic [CNT_W-1:0]      o_count
);

    always_comb begin
        o_count = '0;
        for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
            o_count = o_count + CNT_W'(i_row[i]);
        end
    end

endmodule

// File: rtl/text_line_segmenter.sv
// Finds horizontal text lines (maximal runs of inked rows) in a row stream and emits one
// (start, end, ink) record per line. Define LINE_INK_EN to build the per-line ink accumulator.
module text_line_segmenter
    import seg_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = SEG_ADDR_W,
    parameter int unsigned NOISE_THR  = 0,
    parameter int unsigned MIN_HEIGHT = 2,
    parameter int unsigned INK_WIDTH  = SEG_INK_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  row_valid,
    output logic                  row_ready,
    input  logic [DATA_WIDTH-1:0] row_data,
    input  logic                  row_last,
    output logic                  line_valid,
    input  logic                  line_ready,
    output logic [ADDR_WIDTH-1:0] line_start,
    output logic [ADDR_WIDTH-1:0] line_end,
    output logic [INK_WIDTH-1:0]  line_ink,
    output logic                  frame_done
);

    localparam int unsigned           PW      = pop_width(DATA_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] IDX_MAX = '1;
    localparam logic [ADDR_WIDTH:0]   MIN_H   = (ADDR_WIDTH + 1)'(MIN_HEIGHT);

    seg_state_t            r_state;
    logic [ADDR_WIDTH-1:0] r_idx;
    logic [ADDR_WIDTH-1:0] r_start;
    logic                  r_frame_end;
    logic                  r_row_ready;
    logic                  r_line_valid;
    logic                  r_frame_done;
    line_rec_t             r_rec;

    logic [PW-1:0]         w_pop;
    logic                  w_ink;
    logic                  w_accept;
    logic                  w_close;
    logic                  w_keep;
    logic [ADDR_WIDTH-1:0] w_run_start;
    logic [ADDR_WIDTH-1:0] w_end;
    logic [ADDR_WIDTH:0]   w_height;
    logic [INK_WIDTH-1:0]  w_rec_ink;

    row_popcount #(
        .DATA_WIDTH (DATA_WIDTH),
        .CNT_W      (PW)
    ) u_popcount (
        .i_row   (row_data),
        .o_count (w_pop)
    );

    assign w_ink       = 32'(w_pop) > NOISE_THR;
    assign w_accept    = row_valid && r_row_ready;

    // In GAP an ink row both opens and (if last) closes the run, so it supplies its own start.
    assign w_run_start = (r_state == GAP) ? r_idx : r_start;
    assign w_end       = w_ink ? r_idx : r_idx - ADDR_WIDTH'(1);
    assign w_height    = {1'b0, w_end} - {1'b0, w_run_start} + (ADDR_WIDTH + 1)'(1);
    assign w_keep      = w_height >= MIN_H;
    assign w_close     = w_accept &&
                         (((r_state == GAP) && w_ink && row_last) ||
                          ((r_state == RUN) && (row_last || !w_ink)));

`ifdef LINE_INK_EN
    logic [INK_WIDTH-1:0] r_ink_acc;
    logic [INK_WIDTH-1:0] w_ink_next;
    logic [INK_WIDTH:0]   w_ink_sum;

    assign w_ink_sum  = {1'b0, r_ink_acc} + (INK_WIDTH + 1)'(w_pop);
    assign w_ink_next = (r_state == GAP) ? INK_WIDTH'(w_pop)
                      : (w_ink_sum[INK_WIDTH] ? '1 : w_ink_sum[INK_WIDTH-1:0]);
    assign w_rec_ink  = w_ink ? w_ink_next : r_ink_acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ink_acc <= '0;
        end else if (w_accept && w_ink) begin
            r_ink_acc <= w_ink_next;
        end
    end
`else
    assign w_rec_ink = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_idx        <= '0;
            r_start      <= '0;
            r_frame_end  <= 1'b0;
            r_row_ready  <= 1'b0;
            r_line_valid <= 1'b0;
            r_frame_done <= 1'b0;
            r_rec        <= '0;
        end else begin
            r_frame_done <= 1'b0;
            // Index holds at its maximum rather than wrapping, matching the upstream reader.
            if (w_accept && (r_idx != IDX_MAX)) begin
                r_idx <= r_idx + ADDR_WIDTH'(1);
            end

            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state     <= GAP;
                        r_idx       <= '0;
                        r_frame_end <= 1'b0;
                        r_row_ready <= 1'b1;
                    end
                end

                GAP, RUN: begin
                    if (w_accept) begin
                        if ((r_state == GAP) && w_ink) begin
                            r_start <= r_idx;
                        end
                        if (w_close) begin
                            r_frame_end <= row_last;
                            if (w_keep) begin
                                r_rec.start_row <= SEG_ADDR_W'(w_run_start);
                                r_rec.end_row   <= SEG_ADDR_W'(w_end);
                                r_rec.ink       <= SEG_INK_W'(w_rec_ink);
                                r_line_valid    <= 1'b1;
                                r_row_ready     <= 1'b0;
                                r_state         <= EMIT;
                            end else if (row_last) begin
                                r_row_ready <= 1'b0;
                                r_state     <= FLUSH;
                            end else begin
                                r_state <= GAP;
                            end
                        end else if (row_last) begin
                            r_row_ready <= 1'b0;
                            r_state     <= FLUSH;
                        end else if (w_ink) begin
                            r_state <= RUN;
                        end
                    end
                end

                EMIT: begin
                    if (line_ready) begin
                        r_line_valid <= 1'b0;
                        if (r_frame_end) begin
                            r_state <= FLUSH;
                        end else begin
                            r_row_ready <= 1'b1;
                            r_state     <= GAP;
                        end
                    end
                end

                FLUSH: begin
                    r_frame_done <= 1'b1;
                    r_state      <= IDLE;
                end

                default: begin
                    r_state     <= IDLE;
                    r_row_ready <= 1'b0;
                end
            endcase
        end
    end

    assign row_ready  = r_row_ready;
    assign line_valid = r_line_valid;
    assign frame_done = r_frame_done;
    assign line_start = ADDR_WIDTH'(r_rec.start_row);
    assign line_end   = ADDR_WIDTH'(r_rec.end_row);
    assign line_ink   = INK_WIDTH'(r_rec.ink);

endmodule
